// File: rtl/fuzzy_risk_pkg.sv
// Shared encodings, fuzzy-set breakpoints and widths for the landslide-risk scheduler.
package fuzzy_risk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FUZZ   = 3'd1,
        ST_RULE   = 3'd2,
        ST_DEFUZZ = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int MEM_W = 8;
    localparam int DEN_W = 10;
    localparam int NUM_W = 18;

    localparam logic [2:0] N_SLOTS = 3'd6;
    localparam logic [7:0] V_MAX   = 8'd100;

    localparam logic [7:0] LOW_A  = 8'd0,  LOW_B  = 8'd20, LOW_C  = 8'd40;
    localparam logic [7:0] MED_A  = 8'd30, MED_B  = 8'd50, MED_C  = 8'd70;
    localparam logic [7:0] HIGH_A = 8'd60, HIGH_B = 8'd80, HIGH_C = 8'd100;

    localparam logic [NUM_W-1:0] W_HIGH    = 18'd255;
    localparam logic [NUM_W-1:0] W_MED     = 18'd170;
    localparam logic [NUM_W-1:0] W_LOW     = 18'd85;
    localparam logic [NUM_W-1:0] MEM_SCALE = 18'd255;

    typedef struct packed {
        logic [NUM_W-1:0] dividend;
        logic [DEN_W-1:0] divisor;
    } div_op_t;

    // Divider operands for one triangular membership; out-of-support values divide 0 by 1.
    function automatic div_op_t member_op(input logic [7:0] v, input logic [1:0] set_sel);
        logic [7:0] a, b, c;
        div_op_t    op;
        case (set_sel)
            2'd0:    begin a = LOW_A;  b = LOW_B;  c = LOW_C;  end
            2'd1:    begin a = MED_A;  b = MED_B;  c = MED_C;  end
            default: begin a = HIGH_A; b = HIGH_B; c = HIGH_C; end
        endcase
        op.dividend = '0;
        op.divisor  = DEN_W'(1);
        if (v > a && v <= b) begin
            op.dividend = NUM_W'(v - a) * MEM_SCALE;
            op.divisor  = DEN_W'(b - a);
        end else if (v > b && v <= c) begin
            op.dividend = NUM_W'(c - v) * MEM_SCALE;
            op.divisor  = DEN_W'(c - b);
        end
        return op;
    endfunction

endpackage

// File: rtl/fuzzy_serial_div.sv
// Shared restoring divider: one load cycle then DIV_W shift-subtract steps.
// o_done is visible DIV_W+1 cycles after the cycle i_start was asserted;
// a new i_start may be issued in the done cycle to run back-to-back.
module fuzzy_serial_div import fuzzy_risk_pkg::*; #(
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [DIV_W-1:0] o_quotient
);
    localparam int CNT_W = $clog2(DIV_W + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_div;
    logic [DIV_W-1:0] r_quo;
    logic             w_iter;
    logic [DEN_W:0]   w_shift;
    logic [DEN_W:0]   w_diff;
    logic             w_ge;

    assign w_iter  = r_busy && (r_cnt != '0);
    assign w_shift = {r_rem, r_quo[DIV_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    // Sequencing: load on start, count iterations down, go idle after the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(DIV_W);
        end else if (w_iter) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end else begin
            r_busy <= 1'b0;
        end
    end

    // Arithmetic: dividend bits shift out of r_quo as quotient bits shift in.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (w_iter) begin
            r_rem <= w_ge ? w_diff[DEN_W-1:0] : w_shift[DEN_W-1:0];
            r_quo <= {r_quo[DIV_W-2:0], w_ge};
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == '0);
    assign o_quotient = r_quo;

endmodule

// File: rtl/fuzzy_risk_scheduler.sv
// Multi-cycle landslide-risk controller: six membership divisions and one
// defuzzification division per sample on a single shared serial divider,
// valid/ready on both sides and a hysteretic alarm flag.
module fuzzy_risk_scheduler import fuzzy_risk_pkg::*; #(
    parameter int DIV_W    = 18,
    parameter int ALARM_HI = 200,
    parameter int ALARM_LO = 150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] rain_fall,
    input  logic [7:0] soil_moisture,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] risk,
    output logic       alarm,
    output logic       busy
);
    localparam logic [7:0] ALARM_HI_V = 8'(ALARM_HI);
    localparam logic [7:0] ALARM_LO_V = 8'(ALARM_LO);

    state_t           r_state, w_next_state;
    logic [7:0]       r_rain, r_soil;
    logic [2:0]       r_idx;
    logic [MEM_W-1:0] r_mem [6];
    logic             r_den_zero;
    logic [7:0]       r_risk;
    logic             r_alarm;

    logic             w_accept;
    logic             w_div_start, w_div_busy, w_div_done;
    logic [DIV_W-1:0] w_div_q;
    logic             w_unused_q;
    div_op_t          w_div_op, w_fuzz_op;
    logic [7:0]       w_slot_val;
    logic [1:0]       w_set_sel;
    logic [MEM_W-1:0] w_s1, w_s2, w_s3;
    logic [NUM_W-1:0] w_num;
    logic [DEN_W-1:0] w_den;
    logic [7:0]       w_risk_new;

    function automatic logic [7:0] clamp_pct(input logic [7:0] v);
        return (v > V_MAX) ? V_MAX : v;
    endfunction

    function automatic logic [MEM_W-1:0] fmin(input logic [MEM_W-1:0] x, input logic [MEM_W-1:0] y);
        return (x < y) ? x : y;
    endfunction

    assign w_accept   = in_valid && in_ready;
    // Slots 0..2 are rain low/med/high, 3..5 are soil low/med/high.
    assign w_slot_val = (r_idx < 3'd3) ? r_rain : r_soil;
    assign w_set_sel  = (r_idx < 3'd3) ? r_idx[1:0] : 2'(r_idx - 3'd3);
    assign w_fuzz_op  = member_op(w_slot_val, w_set_sel);

    // r_mem[0..5] holds rain low/med/high, soil low/med/high after the FUZZ pass.
    assign w_s1  = fmin(r_mem[2], r_mem[5]);
    assign w_s2  = fmin(r_mem[1], r_mem[4]);
    assign w_s3  = fmin(r_mem[0], r_mem[3]);
    assign w_num = NUM_W'(w_s1) * W_HIGH + NUM_W'(w_s2) * W_MED + NUM_W'(w_s3) * W_LOW;
    assign w_den = DEN_W'(w_s1) + DEN_W'(w_s2) + DEN_W'(w_s3);

    assign w_risk_new = r_den_zero ? 8'd0 : w_div_q[7:0];
    assign w_unused_q = ^w_div_q[DIV_W-1:MEM_W];

    fuzzy_serial_div #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (DIV_W'(w_div_op.dividend)),
        .i_divisor  (w_div_op.divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; r_idx counts slots already started, so done with r_idx==6 ends FUZZ.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_FUZZ;
            ST_FUZZ:   if (w_div_done && r_idx == N_SLOTS) w_next_state = ST_RULE;
            ST_RULE:   w_next_state = ST_DEFUZZ;
            ST_DEFUZZ: if (w_div_done) w_next_state = ST_HOLD;
            ST_HOLD:   if (out_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs and divider issue; RULE feeds num/den straight into the divider load.
    always_comb begin
        in_ready    = rst_n && (r_state == ST_IDLE);
        busy        = (r_state != ST_IDLE);
        out_valid   = (r_state == ST_HOLD);
        w_div_start = 1'b0;
        w_div_op    = w_fuzz_op;
        case (r_state)
            ST_FUZZ: w_div_start = (r_idx != N_SLOTS) && (!w_div_busy || w_div_done);
            ST_RULE: begin
                w_div_start       = 1'b1;
                w_div_op.dividend = (w_den == '0) ? '0 : w_num;
                w_div_op.divisor  = (w_den == '0) ? DEN_W'(1) : w_den;
            end
            default: ;
        endcase
    end

    // Control and result registers: slot counter, zero-denominator flag, risk and alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_den_zero <= 1'b0;
            r_risk     <= '0;
            r_alarm    <= 1'b0;
        end else begin
            if (w_accept)
                r_idx <= '0;
            else if (r_state == ST_FUZZ && w_div_start)
                r_idx <= r_idx + 3'd1;
            if (r_state == ST_RULE)
                r_den_zero <= (w_den == '0);
            if (r_state == ST_DEFUZZ && w_div_done) begin
                r_risk <= w_risk_new;
                if (w_risk_new >= ALARM_HI_V)     r_alarm <= 1'b1;
                else if (w_risk_new < ALARM_LO_V) r_alarm <= 1'b0;
            end
        end
    end

    // Sample capture with clamping, and membership shift-in as each FUZZ slot completes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rain <= clamp_pct(rain_fall);
            r_soil <= clamp_pct(soil_moisture);
        end
        if (r_state == ST_FUZZ && w_div_done) begin
            for (int i = 0; i < 5; i++) r_mem[i] <= r_mem[i+1];
            r_mem[5] <= w_div_q[MEM_W-1:0];
        end
    end

    assign risk  = r_risk;
    assign alarm = r_alarm;

endmodule

// File: tb/tb_fuzzy_risk_scheduler.sv
// Directed bench for fuzzy_risk_scheduler: hand-computed risk/alarm values,
// fixed 135-cycle latency, back-pressure, handshake corner and mid-sample reset.
module tb_fuzzy_risk_scheduler;

    localparam int LAT = 135;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rain_fall;
    logic [7:0] soil_moisture;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] risk;
    logic       alarm;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    fuzzy_risk_scheduler #(.DIV_W(18), .ALARM_HI(200), .ALARM_LO(150)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rain_fall     (rain_fall),
        .soil_moisture (soil_moisture),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .risk          (risk),
        .alarm         (alarm),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, offer one sample, return just after the accept edge.
    task automatic accept_sample(input logic [7:0] r, input logic [7:0] s, input string tag);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; rain_fall = r; soil_moisture = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
    endtask

    // Count edges from accept to out_valid, then check the result.
    task automatic wait_result(input logic [7:0] exp_risk, input logic exp_alarm, input string tag);
        int lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_risk"}, risk, exp_risk);
        chk({tag, "_alarm"}, alarm, exp_alarm);
        chk({tag, "_in_ready_hold"}, in_ready, 0);
    endtask

    task automatic handshake(input logic [7:0] exp_risk, input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_risk_kept"}, risk, exp_risk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; rain_fall = '0; soil_moisture = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_risk", risk, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // 80/80: rain_high = soil_high = 255 -> risk 255, alarm set.
        accept_sample(8'd80, 8'd80, "hi");
        wait_result(8'd255, 1'b1, "hi");
        handshake(8'd255, "hi");

        // 50/50 -> 170, alarm kept; back-pressure with ignored in_valid pulses.
        accept_sample(8'd50, 8'd50, "mid");
        wait_result(8'd170, 1'b1, "mid");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_valid = 1'b1; rain_fall = 8'd35; soil_moisture = 8'd35; end
            if (i == 7) in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_risk", risk, 170);
            chk("bp_in_ready", in_ready, 0);
        end
        // New sample offered in the same cycle as the output handshake: taken one cycle later.
        in_valid = 1'b1; rain_fall = 8'd20; soil_moisture = 8'd20; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_not_accepted", busy, 0);
        chk("hs_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("low_busy", busy, 1);
        // 20/20: rain_low = soil_low = 255 -> 85, alarm cleared.
        wait_result(8'd85, 1'b0, "low");
        handshake(8'd85, "low");

        // 35/35: low=63, med=63 -> 16065/126 = 127.
        accept_sample(8'd35, 8'd35, "mix");
        wait_result(8'd127, 1'b0, "mix");
        handshake(8'd127, "mix");

        // 90/10: no rule fires (den=0) -> 0.
        accept_sample(8'd90, 8'd10, "den0");
        wait_result(8'd0, 1'b0, "den0");
        handshake(8'd0, "den0");

        // 200/200 clamps to 100 -> every membership 0 -> 0.
        accept_sample(8'd200, 8'd200, "clamp");
        wait_result(8'd0, 1'b0, "clamp");
        handshake(8'd0, "clamp");

        // 170 from alarm=0 stays 0 (inside the hysteresis band).
        accept_sample(8'd50, 8'd50, "band");
        wait_result(8'd170, 1'b0, "band");
        handshake(8'd170, "band");

        // Set alarm again, then abort a sample 60 cycles in with reset.
        accept_sample(8'd80, 8'd80, "hi2");
        wait_result(8'd255, 1'b1, "hi2");
        handshake(8'd255, "hi2");
        accept_sample(8'd50, 8'd50, "abort");
        repeat (59) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_risk", risk, 0);
        chk("abort_alarm", alarm, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        accept_sample(8'd35, 8'd35, "post");
        wait_result(8'd127, 1'b0, "post");
        handshake(8'd127, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
